// File: rtl/alu_bist_driver.sv
// Self-test engine for the 4-bit ALU macro: sweeps every operand pair per opcode,
// folds each sampled result into a 16-bit MISR and compares it with a golden signature.
module alu_bist_driver #(
    parameter int unsigned NUM_OPS       = 16,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic [15:0] golden,
    input  logic [7:0]  result_in,
    output logic [7:0]  alu_operands,
    output logic [3:0]  alu_opcode,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int unsigned OPND_W = 8;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SIG_W  = 16;

    localparam logic [SIG_W-1:0]  SIG_SEED    = 16'hFFFF;
    localparam logic [SIG_W-1:0]  SIG_POLY    = 16'h1021;
    localparam logic [OPND_W-1:0] LAST_OPND   = 8'hFF;
    localparam logic [OPC_W-1:0]  LAST_OPC    = OPC_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0]  LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    state_e             state_q,  state_d;
    logic [OPND_W-1:0]  opnd_q,   opnd_d;
    logic [OPC_W-1:0]   opc_q,    opc_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [SIG_W-1:0]   sig_q,    sig_d;
    logic [SIG_W-1:0]   golden_q, golden_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               pass_q,   pass_d;
    logic [SIG_W-1:0]   sig_fold;
    logic               last_vec;

    // MISR step for the result currently on the bus
    assign sig_fold = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                    ^ {8'h00, result_in};
    assign last_vec = (opnd_q == LAST_OPND) && (opc_q == LAST_OPC);

    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        opc_d    = opc_q;
        settle_d = settle_q;
        sig_d    = sig_q;
        golden_d = golden_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;

        if (ena) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d  = ST_SETTLE;
                        sig_d    = SIG_SEED;
                        golden_d = golden;
                        opnd_d   = '0;
                        opc_d    = '0;
                        settle_d = '0;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        pass_d   = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == LAST_SETTLE) begin
                        state_d  = ST_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    sig_d = sig_fold;
                    if (last_vec) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_fold == golden_q);
                    end else begin
                        // operand is the inner loop; its wrap steps the opcode
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                        opnd_d   = opnd_q + OPND_W'(1);
                        if (opnd_q == LAST_OPND) begin
                            opc_d = opc_q + OPC_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opnd_q   <= '0;
            opc_q    <= '0;
            settle_q <= '0;
            sig_q    <= SIG_SEED;
            golden_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            opc_q    <= opc_d;
            settle_q <= settle_d;
            sig_q    <= sig_d;
            golden_q <= golden_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign alu_operands = opnd_q;
    assign alu_opcode   = opc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign signature    = sig_q;

endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
- Initiator-side self-test engine for the 4-bit ALU macro.
- Sweeps every operand pair and each opcode in `0..NUM_OPS-1` onto the ALU's operand/opcode inputs.
- Samples the ALU result after a programmable settle time and compacts all results into a 16-bit MISR signature.
- Compares the signature against a golden value and reports pass/fail. Sits beside the ALU in the tile and drives its input bus.

Parameters:
- NUM_OPS, 16, number of opcodes swept (1..16); opcodes `0..NUM_OPS-1`.
- SETTLE_CYCLES, 1, cycles a vector is held before its sampling cycle (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ena  input  1  tile enable; when low all state holds.
- start  input  1  one-cycle request to begin a run.
- golden  input  16  expected signature; captured on accepted start.
- result_in  input  8  ALU result bus (`uo_out` of the ALU).
- alu_operands  output  8  operand bus to ALU; [7:4]=A, [3:0]=B.
- alu_opcode  output  4  opcode to ALU (`uio_in[3:0]`).
- busy  output  1  run in progress.
- done  output  1  run finished; held until next accepted start.
- pass  output  1  valid while done; 1 iff signature==golden.
- signature  output  16  current MISR value.

Behaviour:
- Reset
  - One clock; reset is synchronous and active-low, on rst_n sampled at the clk rising edge.
  - Reset values: state IDLE, alu_operands=0x00, alu_opcode=0x0, busy=0, done=0, pass=0, signature=0xFFFF, internal counters 0, golden register 0x0000.
  - Reset mid-run aborts immediately to these values with no partial result.
- ena low: every register holds, including FSM, counters and MISR. start is ignored that cycle. Outputs keep their values.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE/DONE + start=1 (ena=1):
    - signature<=0xFFFF; golden captured.
    - operand counter<=0, opcode counter<=0; alu_operands<=0x00, alu_opcode<=0.
    - busy<=1, done<=0, pass<=0; go to SETTLE with settle counter<=0.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles, then SAMPLE.
  - SAMPLE: one cycle. At its closing edge, result_in is folded into the MISR:
    - sig' = {sig[14:0],1'b0} ^ (sig[15] ? 0x1021 : 0x0000) ^ {8'h00, result_in}.
    - If the vector was not last, advance it and return to SETTLE. The new vector appears on the outputs in the first SETTLE cycle.
    - If it was last, go to DONE with busy<=0, done<=1, pass<=(sig'==golden).
- Vector order: operand counter is inner (0x00..0xFF), opcode counter is outer (0..NUM_OPS-1).
  - Operand wrap from 0xFF to 0x00 increments the opcode.
  - The last vector is operands 0xFF with opcode NUM_OPS-1.
- Timing
  - Each vector is stable for SETTLE_CYCLES+1 cycles. result_in is sampled only in SAMPLE.
  - Run length from the start edge to done=1 is NUM_OPS*256*(SETTLE_CYCLES+1) cycles. Defaults give 8192.
- start while busy is ignored, with no restart.
- start in DONE launches a new run and clears done/pass on that edge.
- DONE holds outputs at the final vector and final signature until start or reset.
- Width rules: counters saturate nowhere. Operand counter is 8-bit wrapping; opcode counter is 4-bit.

Test Plan:
- Reset & idle: assert rst_n=0 for 2 cycles with busy mid-run → busy=0, done=0, pass=0, signature=0xFFFF, alu_operands=0x00, alu_opcode=0x0; no activity without start.
- Single-vector MISR: SETTLE_CYCLES=1, result_in tied to 0x00, start → signature after first SAMPLE = 0xEFDF; alu_operands steps 0x00→0x01 two cycles apart.
- Full sweep vs reference ALU: default params with real ALU attached, golden = model-computed signature → done=1 exactly 8192 cycles after start, pass=1. Repeat with golden^0x0001 → pass=0.
- Ordering/wrap: NUM_OPS=2, monitor the bus → opcode 0 for operands 0x00..0xFF, then opcode 1 starting at 0x00. done follows operand 0xFF of opcode 1; total 1024 cycles.
- Control corners: start pulsed while busy → run length unchanged. ena low 10 cycles mid-run → all outputs frozen, done delayed by exactly 10 cycles, same signature.
- Restart & abort: start in DONE → done/pass cleared next cycle and signature restarts from 0xFFFF. rst_n low mid-run → immediate reset values, and a subsequent start yields the same signature as an uninterrupted run.
